// File: rtl/joy_serializer.sv
// -----------------------------------------------------------------------------
// joy_serializer
//
// Purpose:
//   Serializes the control inputs of two players into a 24-bit frame for an
//   external receiver. The receiver strobes joy_load low to capture the
//   controls in parallel, then clocks the frame out bit 0 first on falling
//   edges of joy_clk. All receiver strobes and controls are asynchronous to
//   clk24 and are synchronized before use.
//
//   Frame order, bit 0 first:
//     joy1_n[8,6,5,4,3,2,1,0], joy2_n[8,6,5,4,3,2,1,0],
//     joy2_n[10,11,9,7],       joy1_n[10,11,9,7]
//
// Optional feature:
//   `define JOY_DEBOUNCE_EN  -> per-input debounce filter (DEBOUNCE_CYCLES
//                               consecutive differing samples before the
//                               filtered value follows the input).
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-sample count for the debounce filter
//
// Ports:
//   clk24       in   1   sole clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   joy1_n      in  12   player-1 controls, active-low, asynchronous
//   joy2_n      in  12   player-2 controls, active-low, asynchronous
//   joy_clk     in   1   serial shift clock from receiver, asynchronous
//   joy_load    in   1   active-low parallel-load strobe, asynchronous
//   joy_data    out  1   serial data, registered
//   bit_index   out  5   index of the bit on joy_data, 24 = idle
//   frame_done  out  1   one-cycle pulse when the last bit has been shifted
// -----------------------------------------------------------------------------
module joy_serializer #(
    parameter int unsigned DEBOUNCE_CYCLES = 24000
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic [11:0] joy1_n,
    input  logic [11:0] joy2_n,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic [4:0]  bit_index,
    output logic        frame_done
);

    localparam logic [4:0] IDX_IDLE = 5'd24;
    localparam logic [4:0] IDX_LAST = 5'd23;

    // Arrange both players' controls into the transmit order (bit 0 = LSB).
    function automatic logic [23:0] build_frame(input logic [11:0] j1,
                                                input logic [11:0] j2);
        build_frame = {j1[7], j1[9], j1[11], j1[10],
                       j2[7], j2[9], j2[11], j2[10],
                       j2[0], j2[1], j2[2], j2[3], j2[4], j2[5], j2[6], j2[8],
                       j1[0], j1[1], j1[2], j1[3], j1[4], j1[5], j1[6], j1[8]};
    endfunction

    // Strobe synchronizers: two flops for metastability, third for edge detect.
    logic        r_clk_s1, r_clk_s2, r_clk_s3;
    logic        r_load_s1, r_load_s2, r_load_s3;
    // Control-input synchronizers.
    logic [11:0] r_j1_s1, r_j1_s2;
    logic [11:0] r_j2_s1, r_j2_s2;
    // Shift engine.
    logic [23:0] r_shift;
    logic [4:0]  r_cnt;
    logic        r_done_pre;
    // Registered outputs.
    logic        r_data;
    logic [4:0]  r_index;
    logic        r_done;

    logic [11:0] w_j1_load;
    logic [11:0] w_j2_load;
    logic [23:0] w_frame;
    logic        w_clk_fall;
    logic        w_load_act;
    logic        w_shift;

    // Synchronize the receiver strobes and the raw control inputs.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
            r_load_s1 <= 1'b1;
            r_load_s2 <= 1'b1;
            r_load_s3 <= 1'b1;
            r_j1_s1   <= 12'hFFF;
            r_j1_s2   <= 12'hFFF;
            r_j2_s1   <= 12'hFFF;
            r_j2_s2   <= 12'hFFF;
        end else begin
            r_clk_s1  <= joy_clk;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
            r_load_s1 <= joy_load;
            r_load_s2 <= r_load_s1;
            r_load_s3 <= r_load_s2;
            r_j1_s1   <= joy1_n;
            r_j1_s2   <= r_j1_s1;
            r_j2_s1   <= joy2_n;
            r_j2_s2   <= r_j2_s1;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    // Counter runs 0..DEBOUNCE_CYCLES-1; the filtered bit flips on the last one.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [23:0]   w_sync;
    logic [23:0]   r_db;
    logic [CW-1:0] r_db_cnt [24];

    assign w_sync = {r_j2_s2, r_j1_s2};

    // Per-input debounce: any sample matching the filtered value restarts the count.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_db <= 24'hFFFFFF;
            for (int i = 0; i < 24; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (w_sync[i] != r_db[i]) begin
                    if (r_db_cnt[i] == CNT_LAST) begin
                        r_db[i]     <= w_sync[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_j1_load = r_db[11:0];
    assign w_j2_load = r_db[23:12];
`else
    assign w_j1_load = r_j1_s2;
    assign w_j2_load = r_j2_s2;
`endif

    assign w_frame    = build_frame(w_j1_load, w_j2_load);
    assign w_clk_fall = r_clk_s3 & ~r_clk_s2;
    assign w_load_act = ~r_load_s2;
    // A falling edge is honoured only once load has been released for two
    // samples, so an edge that coincides with the tail of a load is dropped.
    assign w_shift    = w_clk_fall & r_load_s2 & r_load_s3 & (r_cnt < IDX_IDLE);

    // Shift engine: reset beats load, load beats shift.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_shift    <= 24'hFFFFFF;
            r_cnt      <= IDX_IDLE;
            r_done_pre <= 1'b0;
        end else if (w_load_act) begin
            r_shift    <= w_frame;
            r_cnt      <= 5'd0;
            r_done_pre <= 1'b0;
        end else if (w_shift) begin
            r_shift    <= {1'b1, r_shift[23:1]};
            r_cnt      <= r_cnt + 5'd1;
            r_done_pre <= (r_cnt == IDX_LAST);
        end else begin
            r_done_pre <= 1'b0;
        end
    end

    // Output stage: one register after the engine gives the four-cycle pin
    // latency and keeps joy_data, bit_index and frame_done aligned.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_data  <= 1'b1;
            r_index <= IDX_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_data  <= (r_cnt == IDX_IDLE) ? 1'b1 : r_shift[0];
            r_index <= r_cnt;
            r_done  <= r_done_pre;
        end
    end

    assign joy_data   = r_data;
    assign bit_index  = r_index;
    assign frame_done = r_done;

endmodule

// File: doc/joy_serializer.md
JOY_SERIALIZER -- requirements
Module: joy_serializer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 24000: stable-sample count, in clk24 cycles, required before a debounced input changes; used only with JOY_DEBOUNCE_EN.
REQ-002 clk24  input  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 joy1_n  input  12  player-1 controls, active-low, asynchronous to clk24.
REQ-005 joy2_n  input  12  player-2 controls, active-low, asynchronous to clk24.
REQ-006 joy_clk  input  1  serial shift clock from the receiver, asynchronous.
REQ-007 joy_load  input  1  active-low parallel-load strobe from the receiver, asynchronous.
REQ-008 joy_data  output  1  serial data to the receiver, registered.
REQ-009 bit_index  output  5  index of the bit currently on joy_data, 0..24; 24 means idle.
REQ-010 frame_done  output  1  one-cycle pulse when the last bit has been shifted out.

Function
REQ-011 joy_clk and joy_load SHALL each pass through a 2-flop synchronizer; a third flop SHALL provide edge detection.
REQ-012 Frame order, bit 0 first: joy1_n[8,6,5,4,3,2,1,0], joy2_n[8,6,5,4,3,2,1,0], joy2_n[10,11,9,7], joy1_n[10,11,9,7].
REQ-013 Load phase: while synchronized joy_load is 0, the 24-bit shift register SHALL reload every cycle, bit_index SHALL be 0, and joy_data SHALL equal frame bit 0.
REQ-014 Shift phase: on each synchronized falling edge of joy_clk with joy_load 1 and bit_index < 24, the register SHALL shift, bit_index SHALL increment, and joy_data SHALL present the next frame bit on the following cycle.
REQ-015 Latency from a joy_clk pin falling edge to the joy_data update SHALL be exactly 4 clk24 cycles; rising edges of joy_clk SHALL be ignored.
REQ-016 Transition of bit_index from 23 to 24 SHALL assert frame_done for exactly one cycle.
REQ-017 At bit_index 24, joy_data SHALL be 1, and further falling edges SHALL cause no change and no frame_done pulse.
REQ-018 joy_load going low mid-frame SHALL abort the frame with no frame_done pulse and reload per REQ-013.
REQ-019 A joy_load low level coinciding with a joy_clk falling edge: load SHALL win and no shift SHALL occur.
REQ-020 Input sampling: joy1_n/joy2_n SHALL be double-flop synchronized before loading; loaded bits SHALL not change during the shift phase.

Reset
REQ-021 On reset: joy_data SHALL be 1, bit_index 24, frame_done 0, the shift register all ones, and synchronizer flops 1.
REQ-022 With JOY_DEBOUNCE_EN, reset SHALL also set debounced values to 1 and clear all debounce counters.
REQ-023 Reset asserted mid-frame SHALL take effect on the next clock edge and override load and shift.

Configuration
REQ-024 With macro JOY_DEBOUNCE_EN defined, each of the 24 inputs SHALL have a counter; the debounced value SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles, and any match SHALL clear the counter.
REQ-025 The load path SHALL use the debounced values when JOY_DEBOUNCE_EN is defined.
REQ-026 Without JOY_DEBOUNCE_EN, the synchronized inputs SHALL feed the load path directly and no counter logic SHALL be synthesized.

Verification
REQ-027 Reset, then idle: joy_data=1, bit_index=24, frame_done=0.
REQ-028 joy1_n=12'hFEF (bit 4 pressed), joy2_n=12'hFFF, load pulse, then 24 joy_clk cycles: serial stream is all ones except bit 3 = 0; frame_done pulses once after the 24th falling edge.
REQ-029 joy2_n[11]=0 only: stream bit 17 = 0 and all others 1; joy_data update lags each pin falling edge by exactly 4 cycles.
REQ-030 joy_load low after 10 falling edges: bit_index returns to 0, joy_data = bit 0, and no frame_done pulse occurs.
REQ-031 25th and 26th falling edges after a completed frame: joy_data stays 1, bit_index stays 24, and frame_done does not pulse.
REQ-032 JOY_DEBOUNCE_EN with DEBOUNCE_CYCLES=8: a 5-cycle glitch on joy1_n[0] is not loaded; a 9-cycle stable low is loaded as frame bit 7 = 0.
